// File: rtl/uart_pkg.sv
// uart_pkg: state encodings and oversampling constants shared by uart_rx and uart_tx
package uart_pkg;
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_START  = 3'd1;
    localparam state_t ST_DATA   = 3'd2;
    localparam state_t ST_PARITY = 3'd3;
    localparam state_t ST_STOP   = 3'd4;
    localparam int OVERSAMPLE = 16;
    localparam int MID_TICK   = 7;
endpackage

// File: rtl/rx_sync_2ff.sv
// rx_sync_2ff: 2-flop synchroniser, resets to all ones (idle line level)
//   i_clock, i_reset : clock, synchronous active-high reset
//   i_d [W]          : asynchronous input
//   o_q [W]          : synchronised output
module rx_sync_2ff #(
    parameter int W = 1
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] meta;
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            meta <= {W{1'b1}};
            o_q  <= {W{1'b1}};
        end else begin
            meta <= i_d;
            o_q  <= meta;
        end
    end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x oversampling UART receiver (8N1 default), optional even parity via UART_RX_PARITY_EN
//   i_clock, i_reset : clock, synchronous active-high reset
//   i_tick           : oversample strobe, 16 per bit
//   i_rx             : serial line (async, idles high)
//   o_data           : last received byte
//   o_rx_done        : 1-cycle strobe, outputs valid in that cycle
//   o_frame_err      : stop bit sampled low
//   o_parity_err     : parity mismatch (only with UART_RX_PARITY_EN)
module uart_rx
    import uart_pkg::*;
#(
    parameter int NB_DATA = 8,
    parameter int SB_TICK = 16,
    parameter int NB_TICK = 4
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rx_done,
`ifdef UART_RX_PARITY_EN
    output logic               o_parity_err,
`endif
    output logic               o_frame_err
);
    localparam int NB_N = NB_DATA > 1 ? $clog2(NB_DATA) : 1;
    state_t             state;
    logic [NB_TICK-1:0] s;
    logic [NB_N-1:0]    n;
    logic [NB_DATA-1:0] b;
    logic               rxs;
`ifdef UART_RX_PARITY_EN
    logic               p;
`endif
    rx_sync_2ff #(.W(1)) u_sync (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_d     (i_rx),
        .o_q     (rxs)
    );
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state       <= ST_IDLE;
            s           <= '0;
            n           <= '0;
            b           <= '0;
            o_data      <= '0;
            o_rx_done   <= 1'b0;
            o_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            p            <= 1'b0;
            o_parity_err <= 1'b0;
`endif
        end else begin
            o_rx_done <= 1'b0;
            case (state)
                ST_IDLE: if (!rxs) begin
                    state <= ST_START;
                    s     <= '0;
                end
                ST_START: if (i_tick) begin
                    if (s == NB_TICK'(MID_TICK)) begin
                        // still low at mid start bit: real start, otherwise a glitch
                        state <= rxs ? ST_IDLE : ST_DATA;
                        s     <= '0;
                        n     <= '0;
                    end else
                        s <= s + 1'b1;
                end
                ST_DATA: if (i_tick) begin
                    if (s == NB_TICK'(OVERSAMPLE-1)) begin
                        b <= {rxs, b[NB_DATA-1:1]};
                        s <= '0;
                        if (n == NB_N'(NB_DATA-1))
`ifdef UART_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        else
                            n <= n + 1'b1;
                    end else
                        s <= s + 1'b1;
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: if (i_tick) begin
                    if (s == NB_TICK'(OVERSAMPLE-1)) begin
                        p     <= rxs;
                        s     <= '0;
                        state <= ST_STOP;
                    end else
                        s <= s + 1'b1;
                end
`endif
                ST_STOP: if (i_tick) begin
                    if (s == NB_TICK'(SB_TICK-1)) begin
                        o_data      <= b;
                        o_frame_err <= ~rxs;
                        o_rx_done   <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        o_parity_err <= ^b ^ p;
`endif
                        s     <= '0;
                        state <= ST_IDLE;
                    end else
                        s <= s + 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx (tick every 4 clocks, 64 clocks per bit)
module tb_uart_rx;
    logic       i_clock = 1'b0;
    logic       i_reset;
    logic       i_tick;
    logic       i_rx;
    logic [7:0] o_data;
    logic       o_rx_done;
    logic       o_frame_err;
`ifdef UART_RX_PARITY_EN
    logic       o_parity_err;
    logic       rec_perr[$];
`endif
    int         checks = 0;
    int         errors = 0;
    logic [7:0] rec_data[$];
    logic       rec_ferr[$];
    int         base;

    uart_rx dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_tick       (i_tick),
        .i_rx         (i_rx),
        .o_data       (o_data),
        .o_rx_done    (o_rx_done),
`ifdef UART_RX_PARITY_EN
        .o_parity_err (o_parity_err),
`endif
        .o_frame_err  (o_frame_err)
    );

    always #5 i_clock = ~i_clock;

    initial begin
        int tc;
        tc = 0;
        i_tick = 1'b0;
        forever begin
            @(negedge i_clock);
            tc = tc + 1;
            i_tick = (tc % 4 == 0);
        end
    end

    always @(negedge i_clock) if (o_rx_done) begin
        rec_data.push_back(o_data);
        rec_ferr.push_back(o_frame_err);
`ifdef UART_RX_PARITY_EN
        rec_perr.push_back(o_parity_err);
`endif
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int k);
        repeat (k) @(negedge i_clock);
    endtask

    task automatic send_bit(input logic v);
        i_rx = v;
        wait_clk(64);
    endtask

    // stop_len < 64 holds the stop level only through its sample point, then idles high
    task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop_v, input int stop_len);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(^d ^ par_flip);
`endif
        i_rx = stop_v;
        wait_clk(stop_len);
        i_rx = 1'b1;
        wait_clk(64 - stop_len);
    endtask

    initial begin
        i_reset = 1'b1;
        i_rx    = 1'b1;
        wait_clk(8);
        check("rst_data", o_data, 0);
        check("rst_done", o_rx_done, 0);
        check("rst_ferr", o_frame_err, 0);
`ifdef UART_RX_PARITY_EN
        check("rst_perr", o_parity_err, 0);
`endif
        i_reset = 1'b0;
        wait_clk(64);

        base = rec_data.size();
        send_frame(8'hA5, 1'b0, 1'b1, 64);
        wait_clk(64);
        check("a5_pulses", rec_data.size() - base, 1);
        check("a5_data", rec_data[base], 8'hA5);
        check("a5_ferr", rec_ferr[base], 0);

        base = rec_data.size();
        i_rx = 1'b0;
        wait_clk(16);
        i_rx = 1'b1;
        wait_clk(192);
        check("glitch_pulses", rec_data.size() - base, 0);
        check("glitch_hold", o_data, 8'hA5);

        base = rec_data.size();
        send_frame(8'h3C, 1'b0, 1'b0, 48);
        wait_clk(192);
        check("ferr_pulses", rec_data.size() - base, 1);
        check("ferr_data", rec_data[base], 8'h3C);
        check("ferr_flag", rec_ferr[base], 1);

        base = rec_data.size();
        send_frame(8'h00, 1'b0, 1'b1, 64);
        send_frame(8'hFF, 1'b0, 1'b1, 64);
        wait_clk(64);
        check("b2b_pulses", rec_data.size() - base, 2);
        check("b2b_data0", rec_data[base], 8'h00);
        check("b2b_ferr0", rec_ferr[base], 0);
        check("b2b_data1", rec_data[base+1], 8'hFF);
        check("b2b_ferr1", rec_ferr[base+1], 0);

        base = rec_data.size();
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        i_rx = 1'b1;
        wait_clk(32);
        i_reset = 1'b1;
        wait_clk(4);
        check("inrst_data", o_data, 0);
        check("inrst_done", o_rx_done, 0);
        check("inrst_ferr", o_frame_err, 0);
        i_rx = 1'b0;
        wait_clk(64);
        check("inrst_data2", o_data, 0);
        i_rx = 1'b1;
        wait_clk(16);
        i_reset = 1'b0;
        wait_clk(64);
        check("abort_pulses", rec_data.size() - base, 0);
        send_frame(8'h81, 1'b0, 1'b1, 64);
        wait_clk(64);
        check("post_rst_pulses", rec_data.size() - base, 1);
        check("post_rst_data", rec_data[base], 8'h81);

`ifdef UART_RX_PARITY_EN
        base = rec_data.size();
        send_frame(8'h07, 1'b0, 1'b1, 64);
        send_frame(8'h07, 1'b1, 1'b1, 64);
        wait_clk(64);
        check("par_pulses", rec_data.size() - base, 2);
        check("par_ok_data", rec_data[base], 8'h07);
        check("par_ok", rec_perr[base], 0);
        check("par_bad", rec_perr[base+1], 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
